layer_frame_ctrl: RTL and testbench

//  Sequences the serial config link into the per-layer deserializer path.

---
 rtl/layer_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_layer_frame_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_frame_ctrl.sv
// rtl/layer_frame_ctrl.sv - serial config link sync hunter and 32-bit command framer
module layer_frame_ctrl #(
  parameter logic [15:0] SYNC_WORD = 16'h0DF0,
  parameter logic [3:0]  PASS_CODE = 4'hA,
  parameter logic [15:0] TRAILER   = 16'hBEAF,
  parameter logic [7:0]  LAYER_ID  = 8'h01,
  parameter int unsigned MAX_ERR   = 3
) (
  input  logic       t_clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       bit_en,
  output logic       locked,
  output logic       byte_strobe,
  output logic [1:0] byte_idx,
  output logic [3:0] power_set,
  output logic       cfg_valid,
  output logic       frame_err,
  output logic [3:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, FRAME = 1'b1} state_t;

  localparam logic [4:0] MAX_ERR_W = 5'(MAX_ERR);

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        locked_q, locked_d;
  logic        byte_strobe_q, byte_strobe_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  power_set_q, power_set_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [3:0]  err_cnt_q, err_cnt_d;

  logic [31:0] nxt;
  logic [4:0]  err_inc;
  logic        frame_ok;
  logic        frame_hit;

  assign nxt       = {shreg_q[30:0], data_in};
  assign err_inc   = {1'b0, err_cnt_q} + 5'd1;
  assign frame_ok  = (nxt[31:28] == PASS_CODE) && (nxt[15:0] == TRAILER);
  assign frame_hit = frame_ok && ((nxt[23:16] == LAYER_ID) || (nxt[23:16] == 8'hFF));

  // Next-state logic: everything holds and pulses drop whenever no bit is presented.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    locked_d      = locked_q;
    byte_strobe_d = 1'b0;
    byte_idx_d    = byte_idx_q;
    power_set_d   = power_set_q;
    cfg_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    if (bit_en) begin
      shreg_d = nxt;
      case (state_q)
        HUNT: begin
          locked_d = 1'b0;
          if (nxt[15:0] == SYNC_WORD) begin
            state_d   = FRAME;
            bit_cnt_d = 5'd0;
            locked_d  = 1'b1;
          end
        end
        FRAME: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            byte_strobe_d = 1'b1;
            byte_idx_d    = bit_cnt_q[4:3];
          end
          if (bit_cnt_q == 5'd31) begin
            if (frame_hit) begin
              power_set_d = nxt[27:24];
              cfg_valid_d = 1'b1;
              err_cnt_d   = 4'd0;
            end else if (frame_ok) begin
              err_cnt_d = 4'd0;
            end else begin
              frame_err_d = 1'b1;
              err_cnt_d   = (err_inc > 5'd15) ? 4'hF : err_inc[3:0];
              if (err_inc >= MAX_ERR_W) begin
                state_d   = HUNT;
                locked_d  = 1'b0;
                err_cnt_d = 4'd0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      bit_cnt_q     <= 5'd0;
      shreg_q       <= 32'd0;
      locked_q      <= 1'b0;
      byte_strobe_q <= 1'b0;
      byte_idx_q    <= 2'd0;
      power_set_q   <= 4'd0;
      cfg_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      locked_q      <= locked_d;
      byte_strobe_q <= byte_strobe_d;
      byte_idx_q    <= byte_idx_d;
      power_set_q   <= power_set_d;
      cfg_valid_q   <= cfg_valid_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign byte_strobe = byte_strobe_q;
  assign byte_idx    = byte_idx_q;
  assign power_set   = power_set_q;
  assign cfg_valid   = cfg_valid_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_layer_frame_ctrl.sv
// tb/tb_layer_frame_ctrl.sv - scoreboard bench for layer_frame_ctrl
module tb_layer_frame_ctrl;

  logic       t_clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       locked, byte_strobe, cfg_valid, frame_err;
  logic [1:0] byte_idx;
  logic [3:0] power_set, err_cnt;

  layer_frame_ctrl dut (
    .t_clk(t_clk), .rst(rst), .data_in(data_in), .bit_en(bit_en),
    .locked(locked), .byte_strobe(byte_strobe), .byte_idx(byte_idx),
    .power_set(power_set), .cfg_valid(cfg_valid), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 t_clk = ~t_clk;

  localparam int EV_STROBE = 0;
  localparam int EV_CFG    = 1;
  localparam int EV_ERR    = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t  sb[$];
  bit   fb[$];
  logic [15:0] hist;
  bit   exp_locked;
  int   exp_power;
  int   exp_err;
  int   compared = 0;
  int   mismatched = 0;
  bit   gap_mode = 0;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: sync is found on the last 16 sampled bits; once locked, bits are
  // collected into whole 32-bit frames and judged by the acceptance rules.
  task automatic model_reset();
    hist = 16'h0;
    fb.delete();
    sb.delete();
    exp_locked = 0;
    exp_power = 0;
    exp_err = 0;
  endtask

  task automatic model_bit(input logic b);
    logic [31:0] w;
    bit ok, hit;
    hist = {hist[14:0], b};
    if (!exp_locked) begin
      if (hist == 16'h0DF0) begin
        exp_locked = 1;
        fb.delete();
      end
    end else begin
      fb.push_back(b);
      if (fb.size() % 8 == 0) sb.push_back('{EV_STROBE, fb.size() / 8 - 1});
      if (fb.size() == 32) begin
        w = 32'h0;
        foreach (fb[i]) w = {w[30:0], fb[i]};
        ok  = (w[31:28] == 4'hA) && (w[15:0] == 16'hBEAF);
        hit = ok && (w[23:16] == 8'h01 || w[23:16] == 8'hFF);
        if (hit) begin
          exp_power = int'(w[27:24]);
          exp_err = 0;
          sb.push_back('{EV_CFG, exp_power});
        end else if (ok) begin
          exp_err = 0;
        end else begin
          exp_err = (exp_err >= 15) ? 15 : exp_err + 1;
          if (exp_err >= 3) begin
            exp_locked = 0;
            exp_err = 0;
          end
          sb.push_back('{EV_ERR, exp_err});
        end
        fb.delete();
      end
    end
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
  task automatic cyc(input logic en, input logic b);
    @(negedge t_clk);
    #1;
    bit_en = en;
    data_in = b;
    if (en) model_bit(b);
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode && $urandom_range(3) == 0)
      repeat ($urandom_range(5, 1)) cyc(1'b0, 1'($urandom_range(1)));
    cyc(1'b1, b);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge t_clk);
    #1;
    rst = 1'b1;
    bit_en = 1'b0;
    model_reset();
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_power_set", int'(power_set), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_pulses", int'({byte_strobe, cfg_valid, frame_err}), 0);
    check("rst_byte_idx", int'(byte_idx), 0);
    @(negedge t_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pop_expect(input int kind, input int val, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      check({name, "_unexpected"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_val"}, val, e.val);
    end
  endtask

  // Monitor: pulses are matched against the scoreboard, level outputs against model state.
  always @(negedge t_clk) begin
    if (!rst) begin
      if (byte_strobe) pop_expect(EV_STROBE, int'(byte_idx), "byte_strobe");
      if (cfg_valid)   pop_expect(EV_CFG, int'(power_set), "cfg_valid");
      if (frame_err)   pop_expect(EV_ERR, int'(err_cnt), "frame_err");
      check("locked", int'(locked), int'(exp_locked));
      check("power_set", int'(power_set), exp_power);
      check("err_cnt", int'(err_cnt), exp_err);
    end
  end

  initial begin
    model_reset();
    #3;
    check("init_locked", int'(locked), 0);
    check("init_power_set", int'(power_set), 0);
    check("init_pulses", int'({byte_strobe, cfg_valid, frame_err}), 0);
    do_reset();

    // Scenario 1: sync then a frame for this layer
    send_bits(32'h0DF0, 16);
    send_bits(32'hA201BEAF, 32);
    idle(3);
    check("s1_power_set", int'(power_set), 2);
    check("s1_locked", int'(locked), 1);

    // Scenario 2: back-to-back frames
    send_bits(32'hA301BEAF, 32);
    send_bits(32'hA401BEAF, 32);
    send_bits(32'hA501BEAF, 32);
    idle(2);
    check("s2_power_set", int'(power_set), 5);

    // Scenario 3: rejected frame then broadcast
    send_bits(32'hA7020EAF, 32);
    send_bits(32'hA6FFBEAF, 32);
    idle(2);
    check("s3_power_set", int'(power_set), 6);

    // Scenario 4: three bad trailers drop lock, a new sync relocks
    repeat (3) send_bits(32'hA801BEAE, 32);
    idle(2);
    check("s4_unlocked", int'(locked), 0);
    send_bits(32'h0DF0, 16);
    idle(1);
    check("s4_relocked", int'(locked), 1);
    send_bits(32'hA101BEAF, 32);
    idle(2);

    // Scenario 5: scenario 1 with random bit_en gaps
    do_reset();
    gap_mode = 1;
    send_bits(32'h0DF0, 16);
    send_bits(32'hA201BEAF, 32);
    idle(3);
    check("s5_power_set", int'(power_set), 2);
    gap_mode = 0;

    // Scenario 6: reset after frame bit 20; remaining bits must not lock
    send_bits(32'hA901BEAF, 21);
    do_reset();
    for (int i = 10; i >= 0; i--) send_bit(1'(32'hA901BEAF >> i));
    idle(2);
    check("s6_locked", int'(locked), 0);
    check("s6_power_set", int'(power_set), 0);

    // Random frames with gaps, relocking whenever the model says lock was lost
    gap_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] w;
      logic [7:0] id;
      if (!exp_locked) send_bits(32'h0DF0, 16);
      case ($urandom_range(3))
        0: id = 8'h01;
        1: id = 8'hFF;
        2: id = 8'h02;
        default: id = 8'($urandom);
      endcase
      w[31:28] = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hA;
      w[27:24] = 4'($urandom);
      w[23:16] = id;
      w[15:0]  = ($urandom_range(5) == 0) ? 16'($urandom) : 16'hBEAF;
      send_bits(w, 32);
    end
    gap_mode = 0;
    idle(4);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
